// File: rtl/mat_pkg.sv
// -----------------------------------------------------------------------------
// mat_pkg
// Shared constants, FSM state type and element-packing helper for the
// DIM x DIM signed matrix-multiply sequencer (mat_mult_seq) and its
// dot-product sub-unit (mat_dot_unit).
// No ports (package).
// -----------------------------------------------------------------------------
package mat_pkg;

    localparam int DIM   = 5;                       // matrix dimension
    localparam int W     = 8;                       // element width, two's complement
    localparam int N     = DIM * DIM;               // elements per matrix
    localparam int ACC_W = 2 * W + $clog2(DIM);     // signed dot-product sum width
    localparam int K_W   = $clog2(N);               // issue index width

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Bit offset of element (i,j) inside a packed DIM*DIM*W matrix vector.
    function automatic int elem_off(input int i, input int j);
        return (i * DIM + j) * W;
    endfunction

endpackage

// File: rtl/mat_mult_seq_if.sv
// -----------------------------------------------------------------------------
// mat_mult_seq_if
// Bundles the request/handshake and matrix buses between the register file
// (master) and the matrix-multiply sequencer (slave).
//   start    master->slave  request a multiply (honoured only when idle)
//   mat_a    master->slave  matrix A, element (i,j) at [(i*DIM+j)*W +: W]
//   mat_b    master->slave  matrix B, same packing
//   busy     slave->master  operation in progress (LOAD..DONE)
//   done     slave->master  one-cycle pulse, mat_c valid
//   mat_c    slave->master  result matrix, same packing
//   ovf_map  slave->master  per-element overflow flags, bit i*DIM+j
//   ovf      slave->master  OR of ovf_map
// -----------------------------------------------------------------------------
interface mat_mult_seq_if;
    import mat_pkg::*;

    logic             start;
    logic [N*W-1:0]   mat_a;
    logic [N*W-1:0]   mat_b;
    logic             busy;
    logic             done;
    logic [N*W-1:0]   mat_c;
    logic [N-1:0]     ovf_map;
    logic             ovf;

    modport master (
        output start, mat_a, mat_b,
        input  busy, done, mat_c, ovf_map, ovf
    );

    modport slave (
        input  start, mat_a, mat_b,
        output busy, done, mat_c, ovf_map, ovf
    );

endinterface

// File: rtl/mat_dot_unit.sv
// -----------------------------------------------------------------------------
// mat_dot_unit
// Registered signed DIM-term inner product of one row of A and one column
// of B. One cycle of latency; the full-precision sum and an overflow flag
// (sum outside the signed W-bit range) are both registered.
// Ports:
//   clk  in   clock
//   row  in   DIM packed W-bit signed elements, term t at [t*W +: W]
//   col  in   DIM packed W-bit signed elements, term t at [t*W +: W]
//   sum  out  signed ACC_W-bit sum of the DIM products
//   ovf  out  sum does not fit in W signed bits
// -----------------------------------------------------------------------------
module mat_dot_unit
    import mat_pkg::*;
(
    input  logic                    clk,
    input  logic [DIM*W-1:0]        row,
    input  logic [DIM*W-1:0]        col,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    // Full 2W-bit signed product, sign-extended to the accumulator width.
    function automatic logic signed [ACC_W-1:0] mul_ext(
        input logic signed [W-1:0] x,
        input logic signed [W-1:0] y
    );
        logic signed [2*W-1:0] p;
        p = x * y;
        return {{(ACC_W - 2 * W){p[2*W-1]}}, p};
    endfunction

    logic signed [ACC_W-1:0] acc_p0;
    logic                    ovf_p0;

    always_comb begin
        acc_p0 = '0;
        for (int t = 0; t < DIM; t++) begin
            acc_p0 = acc_p0 + mul_ext(row[t*W +: W], col[t*W +: W]);
        end
        // Fits in W signed bits only when every bit from W-1 upward is a
        // copy of the sign bit.
        ovf_p0 = ~((&acc_p0[ACC_W-1:W-1]) | ~(|acc_p0[ACC_W-1:W-1]));
    end

    // ---- stage p0 -> p1: registered sum and overflow ----
    always_ff @(posedge clk) begin
        sum <= acc_p0;
        ovf <= ovf_p0;
    end

endmodule

// File: rtl/mat_mult_seq.sv
// -----------------------------------------------------------------------------
// mat_mult_seq
// Sequencer computing C = A x B for DIM x DIM signed W-bit matrices on a
// single shared dot-product unit. On start (in IDLE) the operands are
// latched, then one (row i, column j) pair is issued per cycle; each result
// is written into mat_c / ovf_map one cycle after issue.
// Timeline from start sampled in c0: LOAD c1, RUN c2..c26, DRAIN c27,
// DONE (done=1) c28.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous, active-high reset; aborts an operation and clears
//             the result
//   bus  slave modport of mat_mult_seq_if (start, mat_a, mat_b, busy, done,
//        mat_c, ovf_map, ovf)
// Build option:
//   MAT_MULT_SAT_EN  defined: overflowing elements saturate to the W-bit
//                    signed limit matching the sum sign; undefined: they wrap
//                    to the low W bits. Overflow flags are reported either way.
// -----------------------------------------------------------------------------
module mat_mult_seq
    import mat_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mat_mult_seq_if.slave  bus
);

`ifdef MAT_MULT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Reduce a full-precision sum to one W-bit element (wrap or saturate).
    function automatic logic [W-1:0] reduce_elem(
        input logic signed [ACC_W-1:0] s,
        input logic                    o
    );
        logic [W-1:0] r;
        r = s[W-1:0];
        if (SAT_EN && o) begin
            r = (s < 0) ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
        end
        return r;
    endfunction

    state_t                  state;
    logic [K_W-1:0]          k;
    logic [N*W-1:0]          a_lat;
    logic [N*W-1:0]          b_lat;
    logic [DIM*W-1:0]        row_p0;
    logic [DIM*W-1:0]        col_p0;
    logic signed [ACC_W-1:0] sum_p1;
    logic                    ovf_p1;
    logic                    vld_p1;
    logic [K_W-1:0]          idx_p1;
    logic [N*W-1:0]          mat_c_r;
    logic [N-1:0]            ovf_map_r;
    logic                    busy_r;
    logic                    done_r;

    // ---- stage p0: operand select for issue index k ----
    always_comb begin
        row_p0 = '0;
        col_p0 = '0;
        for (int t = 0; t < DIM; t++) begin
            row_p0[t*W +: W] = a_lat[elem_off(int'(k) / DIM, t) +: W];
            col_p0[t*W +: W] = b_lat[elem_off(t, int'(k) % DIM) +: W];
        end
    end

    mat_dot_unit u_dot (
        .clk (clk),
        .row (row_p0),
        .col (col_p0),
        .sum (sum_p1),
        .ovf (ovf_p1)
    );

    // ---- stage p1: write-back plus sequencing FSM ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            k         <= '0;
            a_lat     <= '0;
            b_lat     <= '0;
            vld_p1    <= 1'b0;
            idx_p1    <= '0;
            mat_c_r   <= '0;
            ovf_map_r <= '0;
        end else begin
            // Issue index travels with the dot unit's one-cycle latency.
            vld_p1 <= (state == RUN);
            idx_p1 <= k;

            if (vld_p1) begin
                mat_c_r[int'(idx_p1) * W +: W] <= reduce_elem(sum_p1, ovf_p1);
                ovf_map_r[idx_p1]              <= ovf_p1;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= LOAD;
                        busy_r <= 1'b1;
                    end
                end
                LOAD: begin
                    a_lat     <= bus.mat_a;
                    b_lat     <= bus.mat_b;
                    k         <= '0;
                    ovf_map_r <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    if (k == K_W'(N - 1)) begin
                        // Return k to 0 so operand select never indexes past
                        // the last row while draining.
                        k     <= '0;
                        state <= DRAIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    state  <= DONE;
                    done_r <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.mat_c   = mat_c_r;
    assign bus.ovf_map = ovf_map_r;
    assign bus.ovf     = |ovf_map_r;

endmodule

// File: tb/tb_mat_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_mat_mult_seq
// Self-checking bench for mat_mult_seq. Expected results come from a plain
// integer matrix-product model; timing expectations are counted in cycles
// from the start request (c0). Define MAT_MULT_SAT_EN for both RTL and bench
// to check the saturating build.
// -----------------------------------------------------------------------------
module tb_mat_mult_seq;

    localparam int DIM = 5;
    localparam int W   = 8;
    localparam int N   = DIM * DIM;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mat_mult_seq_if bus ();

    mat_mult_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- reference model ----------------
    function automatic int dot_ref(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                                   input int i, input int j);
        int s;
        s = 0;
        for (int t = 0; t < DIM; t++) begin
            s += int'($signed(a[(i*DIM+t)*W +: W])) * int'($signed(b[(t*DIM+j)*W +: W]));
        end
        return s;
    endfunction

    function automatic logic [N*W-1:0] model_c(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        logic [N*W-1:0] c;
        logic [31:0]    sv;
        int             s;
        c = '0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                s  = dot_ref(a, b, i, j);
                sv = s;
                c[(i*DIM+j)*W +: W] = sv[W-1:0];
`ifdef MAT_MULT_SAT_EN
                if (s > 127)       c[(i*DIM+j)*W +: W] = 8'h7F;
                else if (s < -128) c[(i*DIM+j)*W +: W] = 8'h80;
`endif
            end
        end
        return c;
    endfunction

    function automatic logic [N-1:0] model_ovf(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        logic [N-1:0] om;
        int           s;
        om = '0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                s = dot_ref(a, b, i, j);
                om[i*DIM+j] = (s > 127) || (s < -128);
            end
        end
        return om;
    endfunction

    function automatic logic [N*W-1:0] fill_mat(input int v);
        logic [N*W-1:0] m;
        logic [31:0]    vv;
        vv = v;
        for (int e = 0; e < N; e++) m[e*W +: W] = vv[W-1:0];
        return m;
    endfunction

    function automatic logic [N*W-1:0] rand_mat(input int lo, input int hi);
        logic [N*W-1:0] m;
        logic [31:0]    vv;
        for (int e = 0; e < N; e++) begin
            vv = lo + int'($urandom_range(hi - lo));
            m[e*W +: W] = vv[W-1:0];
        end
        return m;
    endfunction

    // Drive a start pulse for c0; returns just after the edge that ends c0.
    task automatic issue_start(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        @(negedge clk);
        bus.mat_a = a;
        bus.mat_b = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.mat_c !== '0) $display("FAIL reset_mat_c got %h want 0", bus.mat_c); else n_pass++;
        n_checks++; if (bus.ovf_map !== '0) $display("FAIL reset_ovf_map got %h want 0", bus.ovf_map); else n_pass++;
        n_checks++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.ovf); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_identity();
        logic [N*W-1:0] a, b;
        logic [31:0]    vv;
        a = '0;
        b = '0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                vv = i * 5 + j - 12;
                b[(i*DIM+j)*W +: W] = vv[W-1:0];
                a[(i*DIM+j)*W +: W] = (i == j) ? 8'd1 : 8'd0;
            end
        end
        issue_start(a, b);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.busy !== (c <= 28))
                $display("FAIL ident_busy c%0d got %b want %b", c, bus.busy, (c <= 28));
            else n_pass++;
            n_checks++;
            if (bus.done !== (c == 28))
                $display("FAIL ident_done c%0d got %b want %b", c, bus.done, (c == 28));
            else n_pass++;
            if (c == 28) begin
                n_checks++; if (bus.mat_c !== b) $display("FAIL ident_mat_c got %h want %h", bus.mat_c, b); else n_pass++;
                n_checks++; if (bus.ovf !== 1'b0) $display("FAIL ident_ovf got %b want 0", bus.ovf); else n_pass++;
            end
        end
    endtask

    task automatic test_patterns();
        logic [N*W-1:0] a, b, exp_c;
        logic [N-1:0]   exp_om;
        logic [W-1:0]   exp_e;
        int             done_c;
        for (int p = 0; p < 3; p++) begin
            case (p)
                0: begin a = fill_mat(1);   b = fill_mat(1);   exp_e = 8'h05; end
                1: begin a = fill_mat(-1);  b = fill_mat(2);   exp_e = 8'hF6; end
                default: begin
                    a = fill_mat(127); b = fill_mat(127);
`ifdef MAT_MULT_SAT_EN
                    exp_e = 8'h7F;
`else
                    exp_e = 8'h05;
`endif
                end
            endcase
            exp_c  = model_c(a, b);
            exp_om = model_ovf(a, b);
            issue_start(a, b);
            done_c = 0;
            for (int c = 1; c <= 40 && done_c == 0; c++) begin
                @(negedge clk);
                if (bus.done === 1'b1) done_c = c;
            end
            n_checks++; if (done_c != 28) $display("FAIL pat%0d_done_cycle got %0d want 28", p, done_c); else n_pass++;
            n_checks++; if (bus.mat_c !== exp_c) $display("FAIL pat%0d_mat_c got %h want %h", p, bus.mat_c, exp_c); else n_pass++;
            n_checks++; if (bus.mat_c[W-1:0] !== exp_e) $display("FAIL pat%0d_elem00 got %h want %h", p, bus.mat_c[W-1:0], exp_e); else n_pass++;
            n_checks++; if (bus.ovf_map !== exp_om) $display("FAIL pat%0d_ovf_map got %h want %h", p, bus.ovf_map, exp_om); else n_pass++;
            n_checks++; if (bus.ovf !== (p == 2)) $display("FAIL pat%0d_ovf got %b want %b", p, bus.ovf, (p == 2)); else n_pass++;
        end
    endtask

    task automatic test_restart_ignored();
        logic [N*W-1:0] a, b, snap_c;
        logic [N-1:0]   snap_om;
        int             n_done, done_c;
        a = rand_mat(-20, 20);
        b = rand_mat(-20, 20);
        n_done = 0;
        done_c = 0;
        snap_c = '0;
        snap_om = '0;
        issue_start(a, b);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin n_done++; done_c = c; end
            if (c == 28) begin snap_c = bus.mat_c; snap_om = bus.ovf_map; end
            if (c == 3) bus.mat_a = rand_mat(-128, 127);
            if (c == 5 || c == 20) bus.start = 1'b1;
            if (c == 6 || c == 21) bus.start = 1'b0;
        end
        n_checks++; if (n_done != 1) $display("FAIL restart_done_count got %0d want 1", n_done); else n_pass++;
        n_checks++; if (done_c != 28) $display("FAIL restart_done_cycle got %0d want 28", done_c); else n_pass++;
        n_checks++; if (snap_c !== model_c(a, b)) $display("FAIL restart_mat_c got %h want %h", snap_c, model_c(a, b)); else n_pass++;
        n_checks++; if (snap_om !== model_ovf(a, b)) $display("FAIL restart_ovf_map got %h want %h", snap_om, model_ovf(a, b)); else n_pass++;
        n_checks++; if (bus.mat_c !== model_c(a, b)) $display("FAIL restart_hold got %h want %h", bus.mat_c, model_c(a, b)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [N*W-1:0] a, b;
        int             n_done, done_c;
        a = rand_mat(-128, 127);
        b = rand_mat(-128, 127);
        issue_start(a, b);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 15) rst = 1'b1;
        end
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL midrst_done got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.mat_c !== '0) $display("FAIL midrst_mat_c got %h want 0", bus.mat_c); else n_pass++;
        n_checks++; if (bus.ovf !== 1'b0) $display("FAIL midrst_ovf got %b want 0", bus.ovf); else n_pass++;
        rst = 1'b0;
        n_done = 0;
        for (int c = 17; c <= 45; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) n_done++;
        end
        n_checks++; if (n_done != 0) $display("FAIL midrst_stray_done got %0d want 0", n_done); else n_pass++;
        a = rand_mat(-11, 11);
        b = rand_mat(-11, 11);
        issue_start(a, b);
        done_c = 0;
        for (int c = 1; c <= 40 && done_c == 0; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_c = c;
        end
        n_checks++; if (done_c != 28) $display("FAIL midrst_fresh_cycle got %0d want 28", done_c); else n_pass++;
        n_checks++; if (bus.mat_c !== model_c(a, b)) $display("FAIL midrst_fresh_mat_c got %h want %h", bus.mat_c, model_c(a, b)); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0] a1, b1, a2, b2, snap1, snap2;
        int             n_done, d0, d1;
        logic           busy29;
        a1 = rand_mat(-11, 11);
        b1 = rand_mat(-11, 11);
        a2 = rand_mat(-128, 127);
        b2 = rand_mat(-128, 127);
        n_done = 0; d0 = 0; d1 = 0; busy29 = 1'b1;
        snap1 = '0; snap2 = '0;
        @(negedge clk);
        bus.mat_a = a1;
        bus.mat_b = b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (n_done == 0) d0 = c; else d1 = c;
                n_done++;
            end
            if (c == 5) begin bus.mat_a = a2; bus.mat_b = b2; end
            if (c == 28) snap1 = bus.mat_c;
            if (c == 29) busy29 = bus.busy;
            if (c == 31) bus.start = 1'b0;
            if (c == 57) snap2 = bus.mat_c;
        end
        n_checks++; if (n_done != 2) $display("FAIL b2b_done_count got %0d want 2", n_done); else n_pass++;
        n_checks++; if (d0 != 28) $display("FAIL b2b_first_done got %0d want 28", d0); else n_pass++;
        n_checks++; if (d1 != 57) $display("FAIL b2b_second_done got %0d want 57", d1); else n_pass++;
        n_checks++; if (busy29 !== 1'b0) $display("FAIL b2b_idle_gap got %b want 0", busy29); else n_pass++;
        n_checks++; if (snap1 !== model_c(a1, b1)) $display("FAIL b2b_first_mat_c got %h want %h", snap1, model_c(a1, b1)); else n_pass++;
        n_checks++; if (snap2 !== model_c(a2, b2)) $display("FAIL b2b_second_mat_c got %h want %h", snap2, model_c(a2, b2)); else n_pass++;
    endtask

    task automatic test_random();
        logic [N*W-1:0] a, b;
        logic [N-1:0]   exp_om;
        int             done_c;
        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) begin
                a = rand_mat(-11, 11);
                b = rand_mat(-11, 11);
            end else begin
                a = rand_mat(-128, 127);
                b = rand_mat(-128, 127);
            end
            exp_om = model_ovf(a, b);
            issue_start(a, b);
            done_c = 0;
            for (int c = 1; c <= 40 && done_c == 0; c++) begin
                @(negedge clk);
                if (bus.done === 1'b1) done_c = c;
            end
            n_checks++; if (done_c != 28) $display("FAIL rand%0d_done_cycle got %0d want 28", r, done_c); else n_pass++;
            n_checks++; if (bus.mat_c !== model_c(a, b)) $display("FAIL rand%0d_mat_c got %h want %h", r, bus.mat_c, model_c(a, b)); else n_pass++;
            n_checks++; if (bus.ovf_map !== exp_om) $display("FAIL rand%0d_ovf_map got %h want %h", r, bus.ovf_map, exp_om); else n_pass++;
            n_checks++; if (bus.ovf !== (|exp_om)) $display("FAIL rand%0d_ovf got %b want %b", r, bus.ovf, (|exp_om)); else n_pass++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.mat_a = '0;
        bus.mat_b = '0;
        test_reset();
        test_identity();
        test_patterns();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mat_mult_seq.md
Name: mat_mult_seq

Overview:
- Sequencer for a full DIM x DIM signed int8 matrix product C = A x B on one shared inner-product datapath.
- Latches A and B on a start request, then issues one (row i of A, column j of B) pair per cycle to a registered dot-product sub-unit.
- Collects the 25 results into an output matrix, with per-element and sticky overflow flags.
- Sits between the coprocessor's bus-facing register file and the arithmetic datapath; the register file sees only start/busy/done.

Parameters:
- DIM, 5, matrix dimension (rows = cols = DIM).
- W, 8, element width in bits, two's complement.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; sampled only in IDLE.
- mat_a  in  DIM*DIM*W  matrix A; element (i,j) at bits [(i*DIM+j)*W +: W].
- mat_b  in  DIM*DIM*W  matrix B; same packing.
- busy  out  1  high from LOAD through DONE inclusive.
- done  out  1  single-cycle pulse when mat_c is valid.
- mat_c  out  DIM*DIM*W  result matrix; same packing.
- ovf_map  out  DIM*DIM  bit i*DIM+j set if element (i,j) overflowed W bits.
- ovf  out  1  OR of ovf_map for the last completed operation.

Behaviour:
- Reset (synchronous, active-high): state IDLE; busy=0, done=0, mat_c=0, ovf_map=0, ovf=0; operand latches and counters cleared. A reset asserted mid-operation aborts it; no done pulse; partial results discarded (mat_c=0).
- FSM states and transitions:
  - IDLE: start=1 moves to LOAD; any other input stays.
  - LOAD, 1 cycle: latch mat_a/mat_b; set k=0; clear ovf_map; go to RUN.
  - RUN, DIM*DIM cycles: issue row k/DIM and column k%DIM to the dot unit; k increments each cycle; after k=DIM*DIM-1 go to DRAIN.
  - DRAIN, 1 cycle: capture the last dot result.
  - DONE, 1 cycle: done=1; go to IDLE.
- Dot unit: one-cycle registered latency. The result for index k is written into mat_c/ovf_map on the edge that ends the cycle after issue k. The issue index is carried through a 1-stage pipeline register alongside the data.
- Latency: start sampled in cycle c0 gives LOAD in c1, RUN in c2..c26, DRAIN in c27, done=1 in c28 (default DIM).
- Arithmetic:
  - Each product is signed W x W into 2W bits.
  - Sum of DIM products is held in 2W+clog2(DIM) bits, signed (19 bits at defaults).
  - Element result is the low W bits (wrap).
  - Overflow when the sum is outside [-2^(W-1), 2^(W-1)-1].
- ovf updates together with ovf_map and equals |ovf_map at every cycle.
- start while busy=1 is ignored and is not queued. start held high continuously re-triggers one cycle after DONE, i.e. the FSM passes through IDLE for one cycle.
- mat_c/ovf_map hold their values after DONE until the next LOAD clears ovf_map. mat_c is overwritten element by element during RUN/DRAIN.
- mat_a/mat_b may change freely after LOAD; only the latched copy is used.

Optional Feature:
- Macro MAT_MULT_SAT_EN.
- Defined: an overflowing element saturates to 2^(W-1)-1 or -2^(W-1) according to sum sign; ovf_map/ovf are still reported.
- Undefined: element wraps to the low W bits.
- Latency is identical in both builds.

Decomposition:
- Shared package mat_pkg holds:
  - constants DIM and W;
  - derived ACC_W = 2*W+$clog2(DIM);
  - FSM state enum (IDLE, LOAD, RUN, DRAIN, DONE);
  - pack/unpack index function for (i,j) to bit offset.
- One sub-module, mat_dot_unit: registered signed DIM-term dot product, taking a row vector and a column vector and returning the ACC_W sum plus an overflow flag. The saturation/wrap reduction stays in mat_mult_seq.

Test Plan:
- A=identity, B with b(i,j)=i*5+j-12, one start pulse: mat_c==B, ovf=0, done high exactly in c28, busy high c1..c28.
- A all 1, B all 1: every element 5 (0x05), ovf_map=0.
- A all -1 (0xFF), B all 2: every element -10 (0xF6), ovf=0.
- A all 127, B all 127 (sum 80645):
  - without MAT_MULT_SAT_EN: every element 0x05;
  - with MAT_MULT_SAT_EN: every element 0x7F;
  - in both builds: ovf_map all ones, ovf=1.
- start re-pulsed in c5 and c20 of a run: no restart, exactly one done (c28), result matches the first operands even though mat_a changed in c3.
- rst asserted in c15: next cycle busy=0, done=0, mat_c=0, ovf=0; no done pulse follows; a fresh start then completes normally.
